beam_delay_ctrl: RTL

- Per-channel delay-line controller for the beamformer. It sits directly upstream of the 256x16 sample RAM and also consumes that RAM's read data.
- It accepts one ADC sample at a time and writes it into the RAM as a circular buffer. It then reads back the sample written DELAY samples earlier and presents it to the summing stage.
- The RAM has a single address port, write-enable qualified, with combinational read. The controller therefore time-multiplexes each sample into a write cycle followed by a read cycle.

---
 rtl/beam_delay_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/beam_delay_ctrl.sv
// ---------------------------------------------------------------------------
// beam_delay_ctrl
//
// Delay-line controller for one beamformer channel. Incoming ADC samples are
// written into an external single-port RAM that is used as a circular buffer.
// For every sample written, the sample written DELAY samples earlier is read
// back and handed to the summing stage. The RAM has one address port and a
// combinational read, so each sample takes a WRITE cycle followed by a READ
// cycle. This gives a best case of one sample every three clocks.
//
// Ports
//   clk            system clock, everything on the rising edge
//   reset          synchronous active-high reset
//   sample_in      incoming ADC sample
//   sample_valid   sample_in is valid this cycle
//   ready          controller can accept a sample this cycle
//   delay          requested delay in samples, latched when a sample is taken
//   ram_address    RAM address
//   ram_in         RAM write data
//   ram_WE         RAM write enable
//   ram_out        RAM combinational read data
//   delayed_out    delayed sample for the summing stage (held between strobes)
//   delayed_valid  one-cycle strobe, delayed_out has just been updated
//   overflow       sticky flag, a sample was offered while ready was low
// ---------------------------------------------------------------------------
module beam_delay_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] delay,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_WE,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] delayed_out,
  output logic              delayed_valid,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  // Fill count saturates at the buffer depth. It needs one more bit than the
  // address so that a completely full buffer can be told apart from an empty one.
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] d_reg;
  logic [ADDR_W:0]   fill;

  // The controller accepts a sample only in IDLE. While reset is held, ready is
  // forced low so that no upstream stage sees a handshake.
  assign ready = (state == IDLE) && !reset;

  // Main controller FSM. The RAM control outputs are registered and are set up
  // one edge ahead of the state they belong to.
  // - On acceptance, ram_in latches the sample. It is the only copy of the
  //   sample that the controller needs.
  // - Leaving WRITE, the read address is computed as wr_ptr - d_reg. This
  //   subtraction wraps naturally modulo the buffer depth.
  // - Leaving READ, the address already points at the next write slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      d_reg         <= '0;
      fill          <= '0;
      overflow      <= 1'b0;
      delayed_out   <= '0;
      delayed_valid <= 1'b0;
      ram_WE        <= 1'b0;
      ram_address   <= '0;
      ram_in        <= '0;
    end else begin
      delayed_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          ram_address <= wr_ptr;
          if (sample_valid) begin
            ram_in <= sample_in;
            d_reg  <= delay;
            ram_WE <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (sample_valid) begin
            overflow <= 1'b1;
          end
          if (fill != FULL) begin
            fill <= fill + 1'b1;
          end
          ram_WE      <= 1'b0;
          ram_address <= wr_ptr - d_reg;
          state       <= READ;
        end
        READ: begin
          if (sample_valid) begin
            overflow <= 1'b1;
          end
          // Until the buffer holds more than d_reg samples, the slot being read
          // has never been written for this stream, so zero is returned.
          if (fill > {1'b0, d_reg}) begin
            delayed_out <= ram_out;
          end else begin
            delayed_out <= '0;
          end
          delayed_valid <= 1'b1;
          wr_ptr        <= wr_ptr + ADDR_W'(1);
          ram_address   <= wr_ptr + ADDR_W'(1);
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
